diffeq_trace_collector: RTL and testbench

- Downstream stage of the diffeq2 solver: watches solver state (xport/yport/uport) and the solver's own reset every cycle.
- Captures a decimated trajectory of solver steps into a register FIFO. Streams samples out over a valid/ready interface.
- Flags the final converged sample and reports step count and dropped-sample count. Feeds the result DMA/host-readback path.

---
 rtl/diffeq_trace_collector.sv | 161 ++++++++++++++++
 tb/tb_diffeq_trace_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/diffeq_trace_collector.sv
// Decimated trajectory capture for the diffeq2 solver, streamed out through a FWFT register FIFO.
// Optional macro DIFFEQ_TRACE_STEP_TAG_EN widens each sample with the step count at capture time.
module diffeq_trace_collector #(
    parameter int unsigned DECIM = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sol_reset,
    input  logic [31:0]  in_a,
    input  logic [31:0]  in_x,
    input  logic [31:0]  in_y,
    input  logic [31:0]  in_u,
`ifdef DIFFEQ_TRACE_STEP_TAG_EN
    output logic [111:0] out_data,
`else
    output logic [95:0]  out_data,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic [15:0]  step_cnt,
    output logic [15:0]  drop_cnt
);

`ifdef DIFFEQ_TRACE_STEP_TAG_EN
    localparam int unsigned DW = 112;
`else
    localparam int unsigned DW = 96;
`endif
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StFinal,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          last_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic [15:0]   dec_q;

    logic          full, pop, converged;
    logic          push_req, push_last, push_ok, step_evt;
    logic [DW-1:0] push_word;

    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = last_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign converged = (in_x >= in_a);

`ifdef DIFFEQ_TRACE_STEP_TAG_EN
    assign push_word = {step_cnt, in_u, in_y, in_x};
`else
    assign push_word = {in_u, in_y, in_x};
`endif

    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        push_last = 1'b0;
        step_evt  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sol_reset) state_d = StArm;
            end
            StArm: begin
                if (!sol_reset) state_d = StRun;
            end
            StRun: begin
                if (sol_reset) begin
                    state_d = StArm;
                end else if (converged) begin
                    push_req  = 1'b1;
                    push_last = 1'b1;
                end else begin
                    step_evt = 1'b1;
                    push_req = (dec_q == 16'd0);
                end
            end
            StFinal: begin
                if (sol_reset) begin
                    state_d = StArm;
                end else begin
                    push_req  = 1'b1;
                    push_last = 1'b1;
                end
            end
            StDone: begin
                if (sol_reset) state_d = StArm;
            end
            default: state_d = StIdle;
        endcase
        // A slot freed by a same-cycle pop lets a push into a full FIFO through.
        push_ok = push_req && (!full || pop);
        if (push_last) state_d = push_ok ? StDone : StFinal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
            drop_cnt <= '0;
            dec_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            busy    <= (state_d == StRun) || (state_d == StFinal);
            done    <= (state_d == StDone);

            if (state_q == StArm) begin
                step_cnt <= '0;
                drop_cnt <= '0;
                dec_q    <= '0;
            end

            if (step_evt) begin
                step_cnt <= step_cnt + 16'd1;
                dec_q    <= (dec_q == 16'(DECIM - 1)) ? 16'd0 : dec_q + 16'd1;
            end

            // The final sample is retried rather than dropped.
            if (push_req && !push_ok && !push_last && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (push_ok) begin
                mem_q[wr_ptr_q]  <= push_word;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end

            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);

            if (push_ok && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_diffeq_trace_collector.sv
// Scoreboard bench for diffeq_trace_collector: a solver stand-in drives random trajectories,
// a queue-based reference model predicts the output stream, and a monitor checks each handshake.
module tb_diffeq_trace_collector;

    localparam int unsigned DECIM = 3;
    localparam int unsigned DEPTH = 4;
`ifdef DIFFEQ_TRACE_STEP_TAG_EN
    localparam int DW = 112;
`else
    localparam int DW = 96;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_FINAL = 3;
    localparam int M_DONE  = 4;

    logic          clk = 1'b0;
    logic          reset, sol_reset, out_ready;
    logic [31:0]   in_a, in_x, in_y, in_u;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, busy, done;
    logic [15:0]   step_cnt, drop_cnt;

    always #5 clk = ~clk;

    diffeq_trace_collector #(
        .DECIM (DECIM),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sol_reset (sol_reset),
        .in_a      (in_a),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_u      (in_u),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .step_cnt  (step_cnt),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model state
    int mstate = M_IDLE;
    int mcount = 0;
    int mstep  = 0;
    int mdrop  = 0;
    int mdec   = 0;

    // Solver stand-in
    logic [31:0] sa = 0, sx = 0, sy = 0, su = 0, sdx = 1;
    int          srel = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must match the head of the expected queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0h, expected no word", out_data);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("out_data", 128'(out_data), 128'(w.data));
                check("out_last", 128'(out_last), 128'(w.last));
            end
        end
    end

    task automatic model_edge(input bit r, input bit sr, input bit rdy);
        bit pop, want, fin, took, stepped;
        word_t w;
        if (r) begin
            mstate = M_IDLE;
            mcount = 0;
            mstep  = 0;
            mdrop  = 0;
            mdec   = 0;
            exp_q.delete();
            return;
        end
        pop     = (mcount > 0) && rdy;
        want    = 0;
        fin     = 0;
        stepped = 0;
        case (mstate)
            M_IDLE: if (sr) mstate = M_ARM;
            M_ARM: begin
                mstep = 0;
                mdrop = 0;
                mdec  = 0;
                if (!sr) mstate = M_RUN;
            end
            M_RUN: begin
                if (sr) mstate = M_ARM;
                else if (sx >= sa) begin
                    want = 1;
                    fin  = 1;
                end else begin
                    want    = (mdec == 0);
                    stepped = 1;
                end
            end
            M_FINAL: begin
                if (sr) mstate = M_ARM;
                else begin
                    want = 1;
                    fin  = 1;
                end
            end
            default: if (sr) mstate = M_ARM;
        endcase
        took = want && ((mcount < int'(DEPTH)) || pop);
        if (took) begin
`ifdef DIFFEQ_TRACE_STEP_TAG_EN
            w.data = {16'(mstep), su, sy, sx};
`else
            w.data = {su, sy, sx};
`endif
            w.last = fin;
            exp_q.push_back(w);
        end
        mcount = mcount + int'(took) - int'(pop);
        if (want && !took && !fin && mdrop < 65535) mdrop++;
        if (stepped) begin
            mstep = (mstep + 1) % 65536;
            mdec  = (mdec + 1) % int'(DECIM);
        end
        if (fin) mstate = took ? M_DONE : M_FINAL;
    endtask

    // One clock: choose inputs for the coming edge, predict it, then check status after it.
    task automatic step(input bit r, input bit sr, input bit rdy);
        if (sr) begin
            sx   = 0;
            sy   = 0;
            su   = 0;
            srel = 0;
        end else begin
            srel++;
            if (srel >= 3 && sx < sa) begin
                sx = sx + sdx;
                sy = $urandom;
                su = $urandom;
            end
        end
        reset     = r;
        sol_reset = sr;
        out_ready = r ? 1'b0 : rdy;
        in_a      = sa;
        in_x      = sx;
        in_y      = sy;
        in_u      = su;
        model_edge(r, sr, out_ready);
        @(posedge clk);
        #2;
        check("step_cnt", 128'(step_cnt), 128'(mstep));
        check("drop_cnt", 128'(drop_cnt), 128'(mdrop));
        check("busy", 128'(busy), 128'(mstate == M_RUN || mstate == M_FINAL));
        check("done", 128'(done), 128'(mstate == M_DONE));
        check("out_valid", 128'(out_valid), 128'(mcount > 0));
    endtask

    task automatic start_run(input logic [31:0] a, input logic [31:0] dx);
        sa  = a;
        sdx = dx;
        repeat (2) step(0, 1, 0);
    endtask

    task automatic run_until(input int maxc, input int rmode);
        for (int i = 0; i < maxc; i++) begin
            if (mstate == M_DONE) break;
            step(0, 0, (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mcount > 0; i++) step(0, 0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        sol_reset = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_x      = '0;
        in_y      = '0;
        in_u      = '0;
        repeat (3) step(1, 0, 0);
        check("reset_out_data", 128'(out_data), 128'(0));
        check("reset_out_last", 128'(out_last), 128'(0));

        // a=10, dx=1: words at x=0,3,6,9 then x=10 with last
        start_run(10, 1);
        run_until(60, 1);
        drain();
        check("basic_step_cnt", 128'(step_cnt), 128'(10));
        check("basic_done", 128'(done), 128'(1));

        // a=0: immediate convergence
        start_run(0, 1);
        run_until(10, 1);
        drain();
        check("a0_step_cnt", 128'(step_cnt), 128'(0));

        // Backpressure: 10 decimated samples, 4 fit, 6 dropped, final held in FINAL
        start_run(30, 1);
        run_until(50, 0);
        check("bp_drop_cnt", 128'(drop_cnt), 128'(6));
        check("bp_busy", 128'(busy), 128'(1));
        check("bp_step_cnt", 128'(step_cnt), 128'(30));
        run_until(30, 1);
        drain();
        check("bp_done", 128'(done), 128'(1));

        // Abort mid-run, then a short second run
        start_run(100, 1);
        repeat (22) step(0, 0, 1);
        start_run(5, 1);
        run_until(40, 1);
        drain();
        check("abort_step_cnt", 128'(step_cnt), 128'(5));

        // Reset while the FIFO holds 3 words
        start_run(100, 1);
        for (int i = 0; i < 40 && mcount < 3; i++) step(0, 0, 0);
        check("pre_reset_occupancy", 128'(mcount), 128'(3));
        step(1, 0, 0);
        check("post_reset_valid", 128'(out_valid), 128'(0));
        check("post_reset_step", 128'(step_cnt), 128'(0));
        step(0, 0, 0);

        // Randomized runs with random backpressure, aborts and resets
        for (int k = 0; k < 25; k++) begin
            start_run($urandom_range(0, 40), $urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                run_until($urandom_range(1, 20), 2);
                start_run($urandom_range(0, 40), $urandom_range(1, 4));
            end
            if (k % 10 == 9) begin
                run_until($urandom_range(1, 15), 2);
                step(1, 0, 0);
                step(0, 0, 0);
                continue;
            end
            run_until(150, 2);
            drain();
        end
        drain();
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
